cnn_div_seq_22s_8u: RTL and testbench
=====================================

Name: cnn_div_seq_22s_8u

Overview:
- Multi-cycle sequential divider that inverts the conv-layer 14s×8u→22s product path.
- Takes a 22-bit signed dividend (accumulated/product domain) and an 8-bit unsigned divisor (scale or pool count).
- Returns a 14-bit signed quotient, truncated toward zero and saturated, plus a remainder.
- Used for requantization and average-pooling normalisation.
- Uses the standard block-level start/done/idle/ready handshake.

Parameters:
- DIVIDEND_WIDTH, 22, signed dividend width.
- DIVISOR_WIDTH, 8, unsigned divisor width.
- QUOTIENT_WIDTH, 14, signed saturated quotient width.

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  request; sampled only in IDLE.
- ap_ready  out  1  operands accepted this cycle.
- ap_idle  out  1  block is in IDLE.
- ap_done  out  1  one-cycle pulse; results valid.
- din0  in  DIVIDEND_WIDTH  signed dividend.
- din1  in  DIVISOR_WIDTH  unsigned divisor.
- dout  out  QUOTIENT_WIDTH  signed quotient.
- rem_out  out  DIVISOR_WIDTH+1  signed remainder.
- ovf  out  1  quotient was saturated.
- div_by_zero  out  1  din1 was 0.

Behaviour:
- Reset: ap_rst_n low → state IDLE immediately, regardless of current state (reset mid-CALC aborts the division; no ap_done for it).
  - Reset values: dout=0, rem_out=0, ovf=0, div_by_zero=0, ap_done=0, ap_idle=1, ap_ready=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - ap_idle=1.
  - ap_ready = ap_start (combinational).
  - On ap_start=1, at the clock edge:
    - latch the sign of din0, |din0| (22-bit unsigned; -2^21 is representable) and din1;
    - clear the partial remainder and iteration counter;
    - go to CALC.
- CALC:
  - Restoring division, one quotient bit per cycle, MSB first, over exactly DIVIDEND_WIDTH=22 cycles.
  - Partial remainder width is DIVISOR_WIDTH+1.
  - The counter reaching 21 moves the FSM to DONE.
  - ap_start and operand changes are ignored; ap_ready=0, ap_idle=0.
- DONE (one cycle), outputs registered on entry:
  - ap_done=1.
  - The FSM returns to IDLE unconditionally.
- Latency: ap_start accepted in cycle 0 → ap_done high in cycle 23.
  - If ap_start is held high, the next acceptance is in cycle 24, so maximum throughput is 1 result per 24 cycles.
- Result rules (applied when entering DONE):
  - Unsigned quotient Qu and remainder Ru are computed from the magnitudes.
  - Signed results: Q = neg ? -Qu : Qu; R = neg ? -Ru : Ru. This truncates toward zero, and the remainder takes the dividend's sign.
  - Saturation:
    - Q > 8191 → dout=8191, ovf=1.
    - Q < -8192 → dout=-8192, ovf=1.
    - Otherwise dout=Q, ovf=0.
  - rem_out=R always. Identity din0 = Q*din1 + R holds when ovf=0.
- Divide by zero (din1=0):
  - Same fixed latency.
  - div_by_zero=1, rem_out=0, ovf=0.
  - dout=8191 if din0≥0, else -8192.
- Output hold: dout, rem_out, ovf and div_by_zero hold their values until the next DONE; they do not change during IDLE or CALC.
- Flags are recomputed on every result, so no sticky state carries over between operations.

Test Plan:
- Exact inverse: din0=-2088960, din1=255, ap_start one cycle → ap_ready=1 in cycle 0, ap_done in cycle 23, dout=-8192, rem_out=0, ovf=0.
- Truncation and signs:
  - 1000/7 → dout=142, rem_out=6.
  - -1000/7 → dout=-142, rem_out=-6.
  - 6/7 → dout=0, rem_out=6.
- Saturation:
  - 2097151/1 → dout=8191, ovf=1, rem_out=0.
  - -2097152/1 → dout=-8192, ovf=1.
  - -8193*1 → dout=-8192, ovf=1.
- Zero divisor:
  - 500/0 → div_by_zero=1, dout=8191, rem_out=0, ap_done at cycle 23.
  - -5/0 → dout=-8192.
- Handshake:
  - ap_start held high for 60 cycles with changing operands → ap_done pulses exactly in cycles 23 and 47, each for the operands sampled in cycles 0 and 24.
  - Operand changes during CALC do not affect results.
- Reset mid-operation: assert ap_rst_n=0 in cycle 10 of CALC → outputs zero and ap_idle=1 immediately, with no ap_done. A fresh start of 100/3 after release → dout=33, rem_out=1.

Source files
------------

// File: rtl/cnn_div_seq_22s_8u.sv
// Sequential restoring divider: signed dividend / unsigned divisor.
// Produces a saturated signed quotient (truncated toward zero) and a
// remainder that carries the dividend's sign. One quotient bit per cycle,
// block-level start/done/idle/ready handshake.
module cnn_div_seq_22s_8u #(
    parameter int unsigned DIVIDEND_WIDTH = 22,
    parameter int unsigned DIVISOR_WIDTH  = 8,
    parameter int unsigned QUOTIENT_WIDTH = 14
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             ap_start,
    output logic                             ap_ready,
    output logic                             ap_idle,
    output logic                             ap_done,
    input  logic signed [DIVIDEND_WIDTH-1:0] din0,
    input  logic        [DIVISOR_WIDTH-1:0]  din1,
    output logic signed [QUOTIENT_WIDTH-1:0] dout,
    output logic signed [DIVISOR_WIDTH:0]    rem_out,
    output logic                             ovf,
    output logic                             div_by_zero
);

    localparam int unsigned DW = DIVIDEND_WIDTH;
    localparam int unsigned DS = DIVISOR_WIDTH;
    localparam int unsigned QW = QUOTIENT_WIDTH;
    localparam int unsigned RW = DIVISOR_WIDTH + 1;
    localparam int unsigned CW = $clog2(DIVIDEND_WIDTH);

    // Largest positive quotient and most negative quotient in QW bits.
    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
    // Magnitude limits of the unsigned quotient before saturation kicks in.
    localparam logic [DW-1:0] POS_LIM = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_LIM = POS_LIM + DW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            w_load;
    logic            w_step;
    logic            w_last;

    // Operand / working registers.
    logic            r_neg;
    logic [DW-1:0]   r_dvd;      // dividend magnitude, shifts out MSB-first, quotient shifts in
    logic [DS-1:0]   r_dsr;
    logic [DS-1:0]   r_rem;      // partial remainder, always below the divisor
    logic [CW-1:0]   r_cnt;

    // Result registers.
    logic [QW-1:0]   r_dout;
    logic [RW-1:0]   r_rem_out;
    logic            r_ovf;
    logic            r_dbz;

    // Combinational datapath.
    logic [DW-1:0]   w_din0_u;
    logic [DW-1:0]   w_abs;
    logic [RW-1:0]   w_trial;
    logic            w_ge;
    logic [RW-1:0]   w_rem_nxt;
    logic [DW-1:0]   w_quo_nxt;
    logic [QW-1:0]   w_q_mag;
    logic [QW-1:0]   w_q_sgn;
    logic [RW-1:0]   w_rem_sgn;
    logic [QW-1:0]   w_dout;
    logic [RW-1:0]   w_rem_res;
    logic            w_ovf;
    logic            w_dbz;

    // Magnitude of the incoming dividend; the most negative value maps to 2^(DW-1).
    assign w_din0_u = din0;
    assign w_abs    = din0[DW-1] ? (~w_din0_u + DW'(1)) : w_din0_u;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_trial   = {r_rem, r_dvd[DW-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dsr});
    assign w_rem_nxt = w_ge ? (w_trial - {1'b0, r_dsr}) : w_trial;
    assign w_quo_nxt = {r_dvd[DW-2:0], w_ge};

    assign w_last    = (r_cnt == CW'(DW - 1));

    // Signed forms of the final step's quotient and remainder.
    assign w_q_mag   = w_quo_nxt[QW-1:0];
    assign w_q_sgn   = r_neg ? (~w_q_mag + QW'(1)) : w_q_mag;
    assign w_rem_sgn = r_neg ? (~w_rem_nxt + RW'(1)) : w_rem_nxt;

    // Result selection: divide-by-zero, saturation, or the plain signed quotient.
    always_comb begin
        w_dout    = w_q_sgn;
        w_rem_res = w_rem_sgn;
        w_ovf     = 1'b0;
        w_dbz     = 1'b0;
        if (r_dsr == '0) begin
            w_dbz     = 1'b1;
            w_rem_res = '0;
            w_dout    = r_neg ? Q_MIN : Q_MAX;
        end else if (!r_neg && (w_quo_nxt > POS_LIM)) begin
            w_dout = Q_MAX;
            w_ovf  = 1'b1;
        end else if (r_neg && (w_quo_nxt > NEG_LIM)) begin
            w_dout = Q_MIN;
            w_ovf  = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
                if (ap_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then one division step per CALC cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_neg <= 1'b0;
            r_dvd <= '0;
            r_dsr <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_neg <= din0[DW-1];
            r_dvd <= w_abs;
            r_dsr <= din1;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_dvd <= w_quo_nxt;
            r_rem <= w_rem_nxt[DS-1:0];
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Results are registered on the last step and held until the next one.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dout    <= '0;
            r_rem_out <= '0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (w_step && w_last) begin
            r_dout    <= w_dout;
            r_rem_out <= w_rem_res;
            r_ovf     <= w_ovf;
            r_dbz     <= w_dbz;
        end
    end

    assign dout        = r_dout;
    assign rem_out     = r_rem_out;
    assign ovf         = r_ovf;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cnn_div_seq_22s_8u.sv
// Bench for cnn_div_seq_22s_8u: integer-arithmetic reference model with a
// per-cycle compare, plus directed vectors with literal expected results.
module tb_cnn_div_seq_22s_8u;

    logic               ap_clk   = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ap_start = 1'b0;
    logic               ap_ready;
    logic               ap_idle;
    logic               ap_done;
    logic signed [21:0] din0 = '0;
    logic        [7:0]  din1 = '0;
    logic signed [13:0] dout;
    logic signed [8:0]  rem_out;
    logic               ovf;
    logic               div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state: m_cnt is cycles since acceptance (0 = idle).
    int m_cnt  = 0;
    int p_a    = 0;
    int p_b    = 0;
    int e_dout = 0;
    int e_rem  = 0;
    int e_ovf  = 0;
    int e_dbz  = 0;

    cnn_div_seq_22s_8u #(
        .DIVIDEND_WIDTH(22),
        .DIVISOR_WIDTH (8),
        .QUOTIENT_WIDTH(14)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .din0       (din0),
        .din1       (din1),
        .dout       (dout),
        .rem_out    (rem_out),
        .ovf        (ovf),
        .div_by_zero(div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference arithmetic: SV integer division truncates toward zero and
    // the remainder takes the dividend's sign.
    function automatic int f_quot(int a, int b);
        int q;
        if (b == 0) return (a >= 0) ? 8191 : -8192;
        q = a / b;
        if (q > 8191)  return 8191;
        if (q < -8192) return -8192;
        return q;
    endfunction

    function automatic int f_rem(int a, int b);
        if (b == 0) return 0;
        return a % b;
    endfunction

    function automatic int f_ovf(int a, int b);
        int q;
        if (b == 0) return 0;
        q = a / b;
        return (q > 8191 || q < -8192) ? 1 : 0;
    endfunction

    // Behavioural model: accept in idle, results appear 23 cycles later for one cycle.
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_cnt  <= 0;
            e_dout <= 0;
            e_rem  <= 0;
            e_ovf  <= 0;
            e_dbz  <= 0;
        end else if (m_cnt == 0) begin
            if (ap_start) begin
                p_a   <= int'(din0);
                p_b   <= int'(din1);
                m_cnt <= 1;
            end
        end else if (m_cnt == 23) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 22) begin
                e_dout <= f_quot(p_a, p_b);
                e_rem  <= f_rem(p_a, p_b);
                e_ovf  <= f_ovf(p_a, p_b);
                e_dbz  <= (p_b == 0) ? 1 : 0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("idle",  int'(ap_idle),     int'(m_cnt == 0));
            chk("done",  int'(ap_done),     int'(m_cnt == 23));
            chk("ready", int'(ap_ready),    int'((m_cnt == 0) && ap_start));
            chk("dout",  int'(dout),        e_dout);
            chk("rem",   int'(rem_out),     e_rem);
            chk("ovf",   int'(ovf),         e_ovf);
            chk("dbz",   int'(div_by_zero), e_dbz);
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    // Starts one division from an idle cycle and checks the literal result.
    task automatic run_op(string name, int a, int b, int xq, int xr, int xo, int xz);
        int n;
        ap_start = 1'b1;
        din0     = 22'(a);
        din1     = 8'(b);
        #1;
        chk({name, "/ready"}, int'(ap_ready), 1);
        tick();
        ap_start = 1'b0;
        din0     = 22'($urandom);
        din1     = 8'($urandom);
        n = 1;
        while (ap_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "/latency"}, n, 23);
        chk({name, "/dout"}, int'(dout), xq);
        chk({name, "/rem"},  int'(rem_out), xr);
        chk({name, "/ovf"},  int'(ovf), xo);
        chk({name, "/dbz"},  int'(div_by_zero), xz);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #2;
        chk_en = 1'b1;
        chk("rst/dout", int'(dout), 0);
        chk("rst/rem",  int'(rem_out), 0);
        chk("rst/ovf",  int'(ovf), 0);
        chk("rst/dbz",  int'(div_by_zero), 0);
        chk("rst/idle", int'(ap_idle), 1);
        chk("rst/done", int'(ap_done), 0);
        ap_rst_n = 1'b1;
        tick();

        run_op("inverse",  -2088960, 255, -8192,  0, 0, 0);
        run_op("p1000_7",      1000,   7,   142,  6, 0, 0);
        run_op("n1000_7",     -1000,   7,  -142, -6, 0, 0);
        run_op("6_7",             6,   7,     0,  6, 0, 0);
        run_op("satpos",    2097151,   1,  8191,  0, 1, 0);
        run_op("satneg",   -2097152,   1, -8192,  0, 1, 0);
        run_op("m8193",       -8193,   1, -8192,  0, 1, 0);
        run_op("p8191",        8191,   1,  8191,  0, 0, 0);
        run_op("m8192",       -8192,   1, -8192,  0, 0, 0);
        run_op("dz500",         500,   0,  8191,  0, 0, 1);
        run_op("dzm5",           -5,   0, -8192,  0, 0, 1);
        run_op("dz0",             0,   0,  8191,  0, 0, 1);

        // Start held high with operands changing every cycle.
        for (int t = 0; t < 60; t++) begin
            ap_start = 1'b1;
            din0     = 22'(1000 * (t + 1));
            din1     = 8'd7;
            #1;
            chk("held/done", int'(ap_done), int'(t == 23 || t == 47));
            if (t == 23) begin
                chk("held/dout0", int'(dout), 142);
                chk("held/rem0",  int'(rem_out), 6);
            end
            if (t == 47) begin
                chk("held/dout1", int'(dout), 3571);
                chk("held/rem1",  int'(rem_out), 3);
            end
            @(posedge ap_clk);
            #2;
        end
        ap_start = 1'b0;
        repeat (15) tick();
        chk("held/dout2", int'(dout), 7000);

        // Reset in the middle of a division.
        ap_start = 1'b1;
        din0     = 22'(12345);
        din1     = 8'd5;
        tick();
        ap_start = 1'b0;
        repeat (9) tick();
        ap_rst_n = 1'b0;
        #1;
        chk("midrst/dout", int'(dout), 0);
        chk("midrst/rem",  int'(rem_out), 0);
        chk("midrst/idle", int'(ap_idle), 1);
        chk("midrst/done", int'(ap_done), 0);
        repeat (2) tick();
        ap_rst_n = 1'b1;
        repeat (30) tick();
        run_op("after_rst", 100, 3, 33, 1, 0, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
